// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - Lw_Sw_OP encodings (RISC-V funct3 style; loads and stores share codes)
//   - FSM state encodings
//   - request classification and byte-lane helper functions
// -----------------------------------------------------------------------------
package dmem_lsu_pkg;

    // Load ops
    localparam logic [2:0] LB_OP  = 3'b000;
    localparam logic [2:0] LH_OP  = 3'b001;
    localparam logic [2:0] LW_OP  = 3'b010;
    localparam logic [2:0] LBU_OP = 3'b100;
    localparam logic [2:0] LHU_OP = 3'b101;
    // Store ops
    localparam logic [2:0] SB_OP  = 3'b000;
    localparam logic [2:0] SH_OP  = 3'b001;
    localparam logic [2:0] SW_OP  = 3'b010;

    // FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // What an incoming request turns into once decoded
    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,   // neither load nor store: empty response
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2,
        ACC_FAULT = 2'd3    // misaligned, conflicting controls or bad op
    } acc_kind_e;

    function automatic acc_kind_e classify(input logic       rd,
                                           input logic       st,
                                           input logic [2:0] op,
                                           input logic [1:0] lo2);
        acc_kind_e k;
        k = ACC_NONE;
        if (rd && st) begin
            k = ACC_FAULT;
        end else if (rd) begin
            case (op)
                LB_OP, LBU_OP: k = ACC_LOAD;
                LH_OP, LHU_OP: k = lo2[0] ? ACC_FAULT : ACC_LOAD;
                LW_OP:         k = (lo2 != 2'b00) ? ACC_FAULT : ACC_LOAD;
                default:       k = ACC_FAULT;
            endcase
        end else if (st) begin
            case (op)
                SB_OP:   k = ACC_STORE;
                SH_OP:   k = lo2[0] ? ACC_FAULT : ACC_STORE;
                SW_OP:   k = (lo2 != 2'b00) ? ACC_FAULT : ACC_STORE;
                default: k = ACC_FAULT;
            endcase
        end
        return k;
    endfunction

    // Select the addressed lane of a little-endian word and extend it
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  op,
                                                input logic [1:0]  lo2);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo2, 3'b000} +: 8];
        h = lo2[1] ? word[31:16] : word[15:0];
        case (op)
            LB_OP:   r = {{24{b[7]}}, b};
            LBU_OP:  r = {24'h000000, b};
            LH_OP:   r = {{16{h[15]}}, h};
            LHU_OP:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte/half of the old word
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  op,
                                                input logic [1:0]  lo2);
        logic [31:0] r;
        r = word;
        case (op)
            SB_OP: r[{lo2, 3'b000} +: 8] = wdata[7:0];
            SH_OP: begin
                if (lo2[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// -----------------------------------------------------------------------------
// dmem_lsu_if
// Request/response bus of the load/store unit.
//   master : requester (core / testbench) drives the request side
//   slave  : dmem_lsu drives Req_Ready and the response side
// -----------------------------------------------------------------------------
interface dmem_lsu_if;
    import dmem_lsu_pkg::*;

    logic        Req_Valid;
    logic        Req_Ready;
    logic        Read_Ctrl;
    logic        Store_Word_En;
    logic [2:0]  Lw_Sw_OP;
    logic [31:0] Addr;
    logic [31:0] Wr_Data;
    logic        Rsp_Valid;
    logic [31:0] Rd_Data;
    logic        Misalign_Fault;

    modport master (
        output Req_Valid, Read_Ctrl, Store_Word_En, Lw_Sw_OP, Addr, Wr_Data,
        input  Req_Ready, Rsp_Valid, Rd_Data, Misalign_Fault
    );

    modport slave (
        input  Req_Valid, Read_Ctrl, Store_Word_En, Lw_Sw_OP, Addr, Wr_Data,
        output Req_Ready, Rsp_Valid, Rd_Data, Misalign_Fault
    );
endinterface

// File: rtl/dmem_bram.sv
// -----------------------------------------------------------------------------
// dmem_bram
// Single-port word memory with registered (synchronous) read, read-first.
// Contents are never reset.
//   clk     : clock
//   we_i    : word write enable
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : word at addr_i from the previous cycle
// -----------------------------------------------------------------------------
module dmem_bram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store unit in front of an internal word memory. One request at a time:
//   load   : IDLE -> READ -> RESP
//   SW     : IDLE -> WRITE -> RESP
//   SB/SH  : IDLE -> READ -> WRITE -> RESP   (read-modify-write)
//   fault / empty request : IDLE -> RESP
// Ports:
//   Clk    : clock
//   Reset  : synchronous active-high reset (memory contents kept)
//   bus    : dmem_lsu_if.slave request/response bus
// -----------------------------------------------------------------------------
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic     Clk,
    input  logic     Reset,
    dmem_lsu_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [1:0]    state_q,   state_d;
    logic          load_q,    load_d;
    logic          fault_q,   fault_d;
    logic [2:0]    op_q,      op_d;
    logic [1:0]    lo2_q,     lo2_d;
    logic [AW-1:0] idx_q,     idx_d;
    logic [31:0]   wdata_q,   wdata_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    acc_kind_e     req_kind;
    logic          accept;

    assign accept   = bus.Req_Valid && (state_q == ST_IDLE);
    assign req_kind = classify(bus.Read_Ctrl, bus.Store_Word_En,
                               bus.Lw_Sw_OP, bus.Addr[1:0]);

    // The read is launched straight from the request address on the
    // acceptance cycle so the word is ready while in READ.
    assign mem_addr = (state_q == ST_IDLE) ? bus.Addr[AW+1:2] : idx_q;
    // Reset landing on the WRITE cycle must not commit the store.
    assign mem_we   = (state_q == ST_WRITE) && !Reset;

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bram (
        .clk     (Clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        fault_d   = fault_q;
        op_d      = op_q;
        lo2_d     = lo2_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = bus.Lw_Sw_OP;
                    lo2_d   = bus.Addr[1:0];
                    idx_d   = bus.Addr[AW+1:2];
                    wdata_d = bus.Wr_Data;
                    load_d  = (req_kind == ACC_LOAD);
                    fault_d = (req_kind == ACC_FAULT);
                    case (req_kind)
                        ACC_LOAD:  state_d = ST_READ;
                        ACC_STORE: state_d = (bus.Lw_Sw_OP == SW_OP) ? ST_WRITE : ST_READ;
                        default: begin
                            state_d   = ST_RESP;
                            rd_data_d = 32'h0;
                        end
                    endcase
                end
            end
            ST_READ: begin
                if (load_q) begin
                    rd_data_d = load_extend(mem_rdata, op_q, lo2_q);
                    state_d   = ST_RESP;
                end else begin
                    // Sub-word store: merge into the old word, write next cycle
                    wdata_d = store_merge(mem_rdata, wdata_q, op_q, lo2_q);
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                rd_data_d = 32'h0;
                state_d   = ST_RESP;
            end
            default: begin
                fault_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            load_q    <= 1'b0;
            fault_q   <= 1'b0;
            op_q      <= 3'b000;
            lo2_q     <= 2'b00;
            idx_q     <= '0;
            wdata_q   <= 32'h0;
            rd_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            fault_q   <= fault_d;
            op_q      <= op_d;
            lo2_q     <= lo2_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.Req_Ready      = (state_q == ST_IDLE);
    assign bus.Rsp_Valid      = (state_q == ST_RESP);
    assign bus.Misalign_Fault = (state_q == ST_RESP) && fault_q;
    assign bus.Rd_Data        = rd_data_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Scoreboard bench: each request pushes its expected response; a negedge
// monitor pops and checks data, fault flag and acceptance-to-response latency.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] d;
        logic        f;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    exp_t exp_q[$];
    int   acc_q[$];

    dmem_lsu_if bus ();

    dmem_lsu #(
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst && bus.Req_Valid === 1'b1 && bus.Req_Ready === 1'b1)
            acc_q.push_back(cyc);
        if (bus.Rsp_Valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp: got Rd_Data=%h fault=%b, required no response",
                         bus.Rd_Data, bus.Misalign_Fault);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                if (bus.Rd_Data !== e.d || bus.Misalign_Fault !== e.f || (cyc - a) !== e.lat) begin
                    bad++;
                    $display("FAIL rsp: got data=%h fault=%b lat=%0d, required data=%h fault=%b lat=%0d",
                             bus.Rd_Data, bus.Misalign_Fault, cyc - a, e.d, e.f, e.lat);
                end else begin
                    $display("rsp ok: data=%h fault=%b lat=%0d", bus.Rd_Data, bus.Misalign_Fault, cyc - a);
                end
            end
        end else if (!rst && bus.Misalign_Fault !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL fault_outside_resp: got %b, required 0", bus.Misalign_Fault);
        end
    end

    task automatic set_idle();
        bus.Req_Valid     = 1'b0;
        bus.Read_Ctrl     = 1'b0;
        bus.Store_Word_En = 1'b0;
        bus.Lw_Sw_OP      = 3'b000;
        bus.Addr          = 32'h0;
        bus.Wr_Data       = 32'h0;
    endtask

    // Drive one request until accepted; expected response goes to the scoreboard
    task automatic req(input logic rd, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_f, input int lat,
                       input bit hold, output int acc_cyc);
        exp_t e;
        bit   got;
        e.d = exp_d; e.f = exp_f; e.lat = lat;
        exp_q.push_back(e);
        bus.Read_Ctrl     = rd;
        bus.Store_Word_En = st;
        bus.Lw_Sw_OP      = op;
        bus.Addr          = a;
        bus.Wr_Data       = wd;
        bus.Req_Valid     = 1'b1;
        got     = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.Req_Ready === 1'b1) begin
                got     = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: Req_Ready stayed %b, required 1", bus.Req_Ready);
        end
        @(posedge clk);
        #1;
        if (!hold) set_idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.Req_Ready !== 1'b1 || bus.Rsp_Valid !== 1'b0 ||
            bus.Misalign_Fault !== 1'b0 || bus.Rd_Data !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b flt=%b data=%h, required 1 0 0 00000000",
                     bus.Req_Ready, bus.Rsp_Valid, bus.Misalign_Fault, bus.Rd_Data);
        end else $display("reset ok");
        @(posedge clk);
        #1;
    endtask

    task automatic test_word();
        int c;
        req(1'b0, 1'b1, SW_OP, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0, c);
        req(1'b1, 1'b0, LW_OP, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, c);
        drain();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.Rd_Data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_hold: got %h, required deadbeef", bus.Rd_Data);
        end else $display("rd_hold ok");
        @(posedge clk);
        #1;
    endtask

    task automatic test_subword();
        int c;
        req(1'b0, 1'b1, SB_OP,  32'h11, 32'hAAAAAA7F, 32'h0,        1'b0, 3, 1'b0, c);
        req(1'b1, 1'b0, LB_OP,  32'h11, 32'h0,        32'h0000007F, 1'b0, 2, 1'b0, c);
        req(1'b1, 1'b0, LBU_OP, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2, 1'b0, c);
        req(1'b1, 1'b0, LH_OP,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 1'b0, c);
        req(1'b1, 1'b0, LHU_OP, 32'h10, 32'h0,        32'h00007FEF, 1'b0, 2, 1'b0, c);
        req(1'b1, 1'b0, LB_OP,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 1'b0, c);
        req(1'b0, 1'b1, SW_OP,  32'h20, 32'h11223344, 32'h0,        1'b0, 2, 1'b0, c);
        req(1'b0, 1'b1, SH_OP,  32'h22, 32'h5555BEEF, 32'h0,        1'b0, 3, 1'b0, c);
        req(1'b1, 1'b0, LW_OP,  32'h20, 32'h0,        32'hBEEF3344, 1'b0, 2, 1'b0, c);
        req(1'b1, 1'b0, LH_OP,  32'h22, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 1'b0, c);
        drain();
    endtask

    task automatic test_misalign();
        int c;
        req(1'b1, 1'b0, LW_OP,  32'h12, 32'h0,        32'h0, 1'b1, 1, 1'b0, c);
        req(1'b0, 1'b1, SH_OP,  32'h13, 32'h00001111, 32'h0, 1'b1, 1, 1'b0, c);
        req(1'b1, 1'b0, LHU_OP, 32'h11, 32'h0,        32'h0, 1'b1, 1, 1'b0, c);
        req(1'b0, 1'b1, SW_OP,  32'h11, 32'h0,        32'h0, 1'b1, 1, 1'b0, c);
        req(1'b1, 1'b1, LW_OP,  32'h10, 32'h0,        32'h0, 1'b1, 1, 1'b0, c);
        req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0,        32'h0, 1'b1, 1, 1'b0, c);
        req(1'b0, 1'b1, LBU_OP, 32'h10, 32'h0,        32'h0, 1'b1, 1, 1'b0, c);
        req(1'b0, 1'b0, LW_OP,  32'h10, 32'h0,        32'h0, 1'b0, 1, 1'b0, c);
        req(1'b1, 1'b0, LW_OP,  32'h10, 32'h0,        32'hDEAD7FEF, 1'b0, 2, 1'b0, c);
        drain();
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        req(1'b1, 1'b0, LW_OP,  32'h10, 32'h0, 32'hDEAD7FEF, 1'b0, 2, 1'b1, c0);
        req(1'b1, 1'b0, LBU_OP, 32'h11, 32'h0, 32'h0000007F, 1'b0, 2, 1'b0, c1);
        drain();
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (c1 - c0 !== 3) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d cycles, required 3", c1 - c0);
        end else $display("b2b ok: spacing=%0d", c1 - c0);
    endtask

    task automatic test_reset_write();
        int c;
        // SB 0x00 @0x10, reset lands on its WRITE cycle
        bus.Read_Ctrl     = 1'b0;
        bus.Store_Word_En = 1'b1;
        bus.Lw_Sw_OP      = SB_OP;
        bus.Addr          = 32'h10;
        bus.Wr_Data       = 32'h0;
        bus.Req_Valid     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.Req_Ready === 1'b1) break;
        end
        @(posedge clk);         // accepted -> READ
        #1;
        set_idle();
        @(posedge clk);         // -> WRITE
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc_q.delete();
        @(negedge clk);
        total++;
        if (bus.Req_Ready !== 1'b1 || bus.Rsp_Valid !== 1'b0 ||
            bus.Misalign_Fault !== 1'b0 || bus.Rd_Data !== 32'h0) begin
            bad++;
            $display("FAIL reset_in_write: got rdy=%b vld=%b flt=%b data=%h, required 1 0 0 00000000",
                     bus.Req_Ready, bus.Rsp_Valid, bus.Misalign_Fault, bus.Rd_Data);
        end else $display("reset_in_write ok");
        @(posedge clk);
        #1;
        req(1'b1, 1'b0, LW_OP, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0, 2, 1'b0, c);
        drain();
    endtask

    task automatic test_alias();
        int c;
        req(1'b0, 1'b1, SW_OP, DEPTH * 4, 32'h12345678, 32'h0,        1'b0, 2, 1'b0, c);
        req(1'b1, 1'b0, LW_OP, 32'h0,     32'h0,        32'h12345678, 1'b0, 2, 1'b0, c);
        req(1'b1, 1'b0, LW_OP, 32'h10,    32'h0,        32'hDEAD7FEF, 1'b0, 2, 1'b0, c);
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        set_idle();
        test_reset();
        test_word();
        test_subword();
        test_misalign();
        test_back_to_back();
        test_reset_write();
        test_alias();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, 1024, number of 32-bit words in internal data memory (power of two).
REQ-002 SHALL have Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have Req_Valid  input  1  access request present.
REQ-005 SHALL have Req_Ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have Read_Ctrl  input  1  request is a load.
REQ-007 SHALL have Store_Word_En  input  1  request is a store.
REQ-008 SHALL have Lw_Sw_OP  input  3  load/store width and sign op, encoded with the existing LB/LH/LW/LBU/LHU/SB/SH/SW _OP_ defines.
REQ-009 SHALL have Addr  input  32  byte address (ALU result).
REQ-010 SHALL have Wr_Data  input  32  store data, rs2 value.
REQ-011 SHALL have Rsp_Valid  output  1  one-cycle pulse marking completion of an accepted request.
REQ-012 SHALL have Rd_Data  output  32  load result, zero- or sign-extended.
REQ-013 SHALL have Misalign_Fault  output  1  qualifies Rsp_Valid; request was misaligned and was not performed.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, RESP; Req_Ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a request on any cycle with Req_Valid=1 and Req_Ready=1, capturing Read_Ctrl, Store_Word_En, Lw_Sw_OP, Addr and Wr_Data into registers; inputs are don't-care otherwise.
REQ-016 SHALL index memory with Addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (aliasing wrap-around).
REQ-017 SHALL use a synchronous-read memory: the read word is available one cycle after the read address is presented.
REQ-018 Load (LB/LH/LW/LBU/LHU): IDLE -> READ -> RESP; Rsp_Valid asserted 2 cycles after acceptance.
REQ-019 Load SHALL select byte lane Addr[1:0] (LB/LBU) or half lane Addr[1] (LH/LHU), sign-extend for LB/LH, zero-extend for LBU/LHU, and pass the whole word for LW.
REQ-020 SW: IDLE -> WRITE -> RESP; full word written in WRITE; Rsp_Valid 2 cycles after acceptance.
REQ-021 SB/SH: IDLE -> READ -> WRITE -> RESP (read-modify-write); only the addressed byte/half is replaced with Wr_Data[7:0]/[15:0], other bytes retained; Rsp_Valid 3 cycles after acceptance.
REQ-022 Misaligned request (LH/LHU/SH with Addr[0]=1; LW/SW with Addr[1:0]!=0): IDLE -> RESP, no memory write, Misalign_Fault=1 and Rd_Data=0 with Rsp_Valid 1 cycle after acceptance.
REQ-023 Request with Read_Ctrl=Store_Word_En=1 SHALL be treated as misaligned (fault response per REQ-022); request with both 0 SHALL complete IDLE -> RESP with no fault, no write, Rd_Data=0.
REQ-024 Lw_Sw_OP value not valid for the request type (e.g. store op with Read_Ctrl) SHALL produce the fault response per REQ-022.
REQ-025 RESP SHALL last exactly one cycle and return to IDLE; Rsp_Valid and Misalign_Fault are 0 outside RESP.
REQ-026 Rd_Data SHALL hold its last value until the next RESP; stores SHALL set Rd_Data=0 in RESP.
REQ-027 A request arriving on the RESP cycle SHALL not be accepted (Req_Ready=0); it is accepted the following cycle.

Reset
REQ-028 Reset SHALL force IDLE, Req_Ready=1 on the following cycle, Rsp_Valid=0, Misalign_Fault=0, Rd_Data=0.
REQ-029 Reset during READ SHALL abort with no memory write; reset during WRITE SHALL suppress that cycle's write; memory contents are not cleared by Reset.

Structure
REQ-030 Lw_Sw_OP encodings and FSM state encodings SHALL live in the shared defines.vh.
REQ-031 Memory array SHALL be a separate sub-module dmem_bram (single port, synchronous read, word write enable, DEPTH_WORDS parameter).

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10 -> Rsp_Valid 2 cycles after each acceptance, Rd_Data=0xDEADBEEF, no fault.
REQ-033 After REQ-032, SB 0x7F @0x11, LB @0x11, LBU @0x13, LH @0x12 -> word 0xDEAD7FEF; Rd_Data 0x0000007F, 0x000000DE, 0xFFFFDEAD.
REQ-034 LW @0x12 and SH @0x13 -> fault pulse 1 cycle after acceptance, Rd_Data=0, memory @0x10 unchanged.
REQ-035 Req_Valid held high across back-to-back loads -> Req_Ready low in READ/RESP, next request accepted cycle after RESP, no request lost or duplicated.
REQ-036 Reset asserted in WRITE of SB 0x00 @0x10 -> memory @0x10 unchanged, IDLE, all outputs 0, Req_Ready=1 next cycle.
REQ-037 SW 0x12345678 @(DEPTH_WORDS*4) then LW @0x0 -> Rd_Data=0x12345678 (address alias).
